divider_result_buf: RTL

//   Downstream stage of the pipelined restoring divider. Captures each 1-cycle
//   res_rdy strobe (quotient + remainder) into a small FWFT FIFO and presents it
//   to the consumer over a valid/ready handshake. The divider has no backpressure,
//   so this block also tracks in-flight divides and drives a credit (issue_ok)

---
 rtl/divider_result_buf.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/divider_result_buf.sv
// -----------------------------------------------------------------------------
// divider_result_buf
//
// Result buffer behind the pipelined restoring divider. Each one-cycle result
// strobe (quotient + remainder) is captured into a small first-word-fall-through
// FIFO. The head entry is offered to the consumer over a valid/ready handshake.
// The divider cannot be stalled, so this block also counts divides in flight
// and raises a credit (o_issue_ok) that the issuer must see high before it
// starts a divide.
//
// Handshake: a transfer happens on a rising clk edge where o_out_valid and
// i_out_ready are both high. o_out_valid depends only on registered state.
// o_out_q/o_out_r are valid whenever o_out_valid is high and hold steady until
// the transfer. i_out_ready may be high while o_out_valid is low, which has no
// effect.
//
// Optional feature macro: DIVRES_STATS_EN adds accepted/dropped result counters.
//
// Ports
//   clk          clock, all state on the rising edge
//   rstn         asynchronous active-low reset
//   i_issue      upstream starts one divide this cycle
//   o_issue_ok   credit: a divide started this cycle is guaranteed a FIFO slot
//   i_res_rdy    divider result strobe
//   i_res_q      divider quotient
//   i_res_r      divider remainder
//   o_out_valid  head entry valid
//   i_out_ready  consumer accepts the head entry
//   o_out_q      head quotient
//   o_out_r      head remainder
//   o_level      FIFO occupancy, 0..DEPTH
//   o_ovf        sticky flag: a result was dropped because the FIFO was full
//   o_res_cnt    (DIVRES_STATS_EN) accepted results, wraps at 2^16
//   o_drop_cnt   (DIVRES_STATS_EN) dropped results, saturates at 16'hFFFF
//   i_ovf_clr    clears o_ovf; a drop in the same cycle wins
// -----------------------------------------------------------------------------
module divider_result_buf #(
    parameter int Q_W   = 5,
    parameter int R_W   = 3,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_issue,
    output logic                         o_issue_ok,
    input  logic                         i_res_rdy,
    input  logic [Q_W-1:0]               i_res_q,
    input  logic [R_W-1:0]               i_res_r,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [Q_W-1:0]               o_out_q,
    output logic [R_W-1:0]               o_out_r,
    output logic [$clog2(DEPTH):0]       o_level,
    output logic                         o_ovf,
`ifdef DIVRES_STATS_EN
    output logic [15:0]                  o_res_cnt,
    output logic [15:0]                  o_drop_cnt,
`endif
    input  logic                         i_ovf_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int W     = Q_W + R_W;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_level;
    logic [CNT_W-1:0] r_inflight;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W:0]   w_committed;

    assign w_full = (r_level == CNT_W'(DEPTH));
    assign w_pop  = (r_level != '0) & i_out_ready;
    // A full FIFO can still accept a result when the head leaves this cycle.
    assign w_push = i_res_rdy & (~w_full | w_pop);
    assign w_drop = i_res_rdy & ~w_push;

    // Slots already claimed: stored results plus divides that will still land.
    assign w_committed = {1'b0, r_level} + {1'b0, r_inflight};

    assign o_issue_ok  = (w_committed < (CNT_W+1)'(DEPTH));
    assign o_out_valid = (r_level != '0);
    assign o_out_q     = r_mem[r_rd_ptr][W-1:R_W];
    assign o_out_r     = r_mem[r_rd_ptr][R_W-1:0];
    assign o_level     = r_level;
    assign o_ovf       = r_ovf;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {i_res_q, i_res_r};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // In-flight divides: saturates at DEPTH, never underflows on a stray result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= '0;
        end else if (i_issue && !i_res_rdy) begin
            if (r_inflight != CNT_W'(DEPTH)) begin
                r_inflight <= r_inflight + 1'b1;
            end
        end else if (i_res_rdy && !i_issue) begin
            if (r_inflight != '0) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end
    end

`ifdef DIVRES_STATS_EN
    logic [15:0] r_res_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_res_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_res_cnt <= r_res_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign o_res_cnt  = r_res_cnt;
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
